// File: rtl/mac_pkg.sv
// Shared types and default constants for the MAC / NN datapath stages.
package mac_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NUM_INPUTS = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_clip.sv
// Signed saturating narrow: clips an IN_W-bit value into OUT_W bits.
module sat_clip #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);

  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  // Bits above the output sign must all match the output sign to fit.
  logic [IN_W-OUT_W:0] top;
  assign top = in_i[IN_W-1:OUT_W-1];

  // Pass through when representable, otherwise clamp toward the input sign.
  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if (!((&top) || (~|top)))
      out_o = in_i[IN_W-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/mac_accum.sv
// Dot-product MAC: accumulates NUM_INPUTS signed products at full precision,
// then saturates the final sum to 2*WIDTH bits and holds it for downstream.
module mac_accum
  import mac_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   act_in,
  input  logic signed [WIDTH-1:0]   wgt_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] acc_out
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + $clog2(NUM_INPUTS);
  // NUM_INPUTS=1 still needs a 1-bit counter to stay a legal vector.
  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [PW-1:0]     res_q, res_d;

  logic signed [PW-1:0]     act_x, wgt_x, prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [PW-1:0]     sum_sat;
  logic                     accept, done, out_hs;

  // Full-width signed product and running sum; accumulator is wide enough
  // that only the final result ever needs clipping.
  assign act_x = PW'(act_in);
  assign wgt_x = PW'(wgt_in);
  assign prod  = act_x * wgt_x;
  assign sum   = acc_q + ACC_W'(prod);

  assign accept = in_valid && in_ready;
  assign done   = accept && (cnt_q == LAST);
  assign out_hs = out_valid && out_ready;

  sat_clip #(.IN_W(ACC_W), .OUT_W(PW)) u_sat (
    .in_i  (sum),
    .out_o (sum_sat)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACCUM;
    else     state_q <= state_d;
  end

  // FSM next state; clr overrides any beat or handshake.
  always_comb begin
    state_d = state_q;
    if (clr) state_d = ST_ACCUM;
    else begin
      case (state_q)
        ST_ACCUM: if (done)   state_d = ST_HOLD;
        ST_HOLD:  if (out_hs) state_d = ST_ACCUM;
        default:              state_d = ST_ACCUM;
      endcase
    end
  end

  // FSM outputs: handshake flags follow state directly.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready  = 1'b1;
      ST_HOLD:  out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // Datapath next state; completing beat latches the clipped sum and rewinds.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (done) begin
      res_d = sum_sat;
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign acc_out = res_q;

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the signed operand width; the result is 2*WIDTH bits and feeds the ReLU stage directly.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, giving the number of products accumulated per result; legal range 1..256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous abort of the current accumulation.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-008 SHALL have port act_in, input, WIDTH bits, signed: activation operand.
REQ-009 SHALL have port wgt_in, input, WIDTH bits, signed: weight operand.
REQ-010 SHALL have port out_valid, output, 1 bit: acc_out holds a completed result.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-012 SHALL have port acc_out, output, 2*WIDTH bits, signed: saturated dot-product result.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept an input beat only when in_valid and in_ready are both 1 in the same cycle.
REQ-015 SHALL, on each accepted beat, add act_in*wgt_in (full 2*WIDTH signed product) to an internal accumulator of 2*WIDTH+clog2(NUM_INPUTS) bits, so the accumulator never overflows internally.
REQ-016 SHALL count accepted beats from 0 to NUM_INPUTS-1; the beat that arrives while the count is NUM_INPUTS-1 completes the result.
REQ-017 SHALL, on the completing beat, register the saturated final sum into acc_out and enter HOLD; out_valid rises on the cycle after the last beat (latency 1).
REQ-018 SHALL saturate the final sum to [-2^(2*WIDTH-1), 2^(2*WIDTH-1)-1]; only the final sum is saturated, never intermediate sums.
REQ-019 SHALL hold acc_out and out_valid stable in HOLD until out_valid and out_ready are both 1 in the same cycle.
REQ-020 SHALL, on output handshake, return to ACCUM with accumulator and count cleared; in_ready=1 the next cycle, with no back-to-back bypass.
REQ-021 SHALL, when clr=1, clear the accumulator and count, drop out_valid and enter ACCUM next cycle, from either state.
REQ-022 SHALL give clr priority over a simultaneous input beat or output handshake; the beat is discarded and the result is lost.
REQ-023 SHALL ignore act_in/wgt_in while not in_ready; in_valid without in_ready SHALL NOT change state.
REQ-024 SHALL, when NUM_INPUTS=1, complete on every accepted beat.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state=ACCUM, count=0, accumulator=0, acc_out=0, out_valid=0; in_ready=1 after reset releases.
REQ-026 SHALL, on reset asserted mid-accumulation or in HOLD, discard all partial and held results; the first result after reset uses only beats accepted after reset.

Structure
REQ-027 SHALL take the FSM state type (ACCUM/HOLD) and the default WIDTH/NUM_INPUTS constants from a shared package mac_pkg.
REQ-028 SHALL place saturation in a combinational sub-module sat_clip (parameterised input and output widths), reusable by other NN stages.
REQ-029 SHALL keep the multiplier inline; there SHALL be no pipelining inside the multiply-add.

Verification (WIDTH=8, NUM_INPUTS=4)
REQ-030 SHALL cover basic accumulation: act={1,2,3,4}, wgt={5,6,7,8}, in_valid continuous -> acc_out=70 (0x0046), out_valid 1 cycle after the 4th beat.
REQ-031 SHALL cover positive saturation: four beats of act=-128, wgt=-128 (sum 65536) -> acc_out=0x7FFF; also act={100,-100,100,-100}, wgt=100 -> acc_out=0, with no intermediate clipping.
REQ-032 SHALL cover negative saturation: four beats of act=-128, wgt=127 (sum -65024) -> acc_out=0x8000.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid=1, acc_out unchanged, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-034 SHALL cover clr/reset mid-operation: clr (or rst) after 2 beats, then beats {1,1,1,1}x{2,2,2,2} -> acc_out=8; clr together with the 4th beat -> no out_valid, count restarts at 0.
